// File: rtl/ncl_sync_tx.sv
// ncl_sync_tx: synchronous-to-NCL boundary transmitter.
// Accepts single-rail words over valid/ready and presents them as dual-rail
// DATA wavefronts, returning the rails to NULL once the receiver's
// completion acknowledge (ki) requests null. ki is asynchronous and is
// brought into the clock domain through a flop chain before any decision.
module ncl_sync_tx #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1023
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic [WIDTH-1:0] rail1,
    output logic [WIDTH-1:0] rail0,
    input  logic             ki,
    output logic             timeout,
    output logic [15:0]      tx_count
);

    localparam int              CNT_W       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
    localparam bit              TIMEOUT_EN  = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        ST_WAIT_RFD = 2'd0,
        ST_IDLE     = 2'd1,
        ST_WAIT_RFN = 2'd2
    } state_t;

    state_t                 state_r;
    state_t                 state_s;
    logic [SYNC_STAGES-1:0] ki_sync_r;
    logic                   ki_s;
    logic [WIDTH-1:0]       rail1_r;
    logic [WIDTH-1:0]       rail0_r;
    logic [WIDTH-1:0]       rail1_s;
    logic [WIDTH-1:0]       rail0_s;
    logic [CNT_W-1:0]       wait_cnt_r;
    logic [CNT_W-1:0]       wait_cnt_s;
    logic                   timeout_r;
    logic                   timeout_s;
    logic [15:0]            tx_count_r;
    logic [15:0]            tx_count_s;
    logic                   waiting_s;

    // Only the final synchronizer stage is trusted as the acknowledge.
    assign ki_s     = ki_sync_r[SYNC_STAGES-1];
    assign in_ready = (state_r == ST_IDLE);
    assign rail1    = rail1_r;
    assign rail0    = rail0_r;
    assign timeout  = timeout_r;
    assign tx_count = tx_count_r;

    // Metastability filter for the asynchronous acknowledge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ki_sync_r <= '0;
        end else begin
            ki_sync_r <= {ki_sync_r[SYNC_STAGES-2:0], ki};
        end
    end

    // Four-phase sequencing: next state, next rails, completion count and wait watchdog.
    always_comb begin
        state_s    = state_r;
        rail1_s    = rail1_r;
        rail0_s    = rail0_r;
        tx_count_s = tx_count_r;
        timeout_s  = timeout_r;
        wait_cnt_s = wait_cnt_r;
        waiting_s  = 1'b0;

        case (state_r)
            ST_WAIT_RFD: begin
                // Rails are already NULL here; keep them there until data is requested.
                rail1_s   = '0;
                rail0_s   = '0;
                waiting_s = 1'b1;
                if (ki_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_WAIT_RFD;
                end
            end
            ST_IDLE: begin
                // A dropped ki here is a protocol violation; it is simply ignored.
                if (in_valid) begin
                    rail1_s = in_data;
                    rail0_s = ~in_data;
                    state_s = ST_WAIT_RFN;
                end else begin
                    rail1_s = '0;
                    rail0_s = '0;
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT_RFN: begin
                waiting_s = 1'b1;
                if (!ki_s) begin
                    rail1_s    = '0;
                    rail0_s    = '0;
                    tx_count_s = tx_count_r + 16'd1;
                    state_s    = ST_WAIT_RFD;
                end else begin
                    state_s = ST_WAIT_RFN;
                end
            end
            default: begin
                rail1_s = '0;
                rail0_s = '0;
                state_s = ST_WAIT_RFD;
            end
        endcase

        // Counter restarts on every state entry and saturates at the limit.
        if (state_s != state_r) begin
            wait_cnt_s = '0;
        end else if (waiting_s) begin
            if (TIMEOUT_EN && (wait_cnt_r == TIMEOUT_CNT)) begin
                timeout_s = 1'b1;
            end else if (wait_cnt_r != TIMEOUT_CNT) begin
                wait_cnt_s = wait_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                wait_cnt_s = wait_cnt_r;
            end
        end else begin
            wait_cnt_s = wait_cnt_r;
        end
    end

    // State, rail and status registers; reset drops rails to NULL at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_WAIT_RFD;
            rail1_r    <= '0;
            rail0_r    <= '0;
            tx_count_r <= 16'd0;
            timeout_r  <= 1'b0;
            wait_cnt_r <= '0;
        end else begin
            state_r    <= state_s;
            rail1_r    <= rail1_s;
            rail0_r    <= rail0_s;
            tx_count_r <= tx_count_s;
            timeout_r  <= timeout_s;
            wait_cnt_r <= wait_cnt_s;
        end
    end

endmodule

// File: tb/tb_ncl_sync_tx.sv
// Testbench for ncl_sync_tx: directed sequence plus a randomized stream,
// with the receiver side played by the bench and a rail-protocol monitor.
module tb_ncl_sync_tx;

    localparam int WIDTH = 8;
    localparam int SYNC  = 2;
    localparam int TMO   = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_ready;
    logic [WIDTH-1:0] rail1;
    logic [WIDTH-1:0] rail0;
    logic             ki = 1'b1;
    logic             timeout;
    logic [15:0]      tx_count;

    int comp_cnt = 0;
    int fail_cnt = 0;
    int viol_cnt = 0;
    logic [WIDTH-1:0] prev1 = '0;
    logic [WIDTH-1:0] prev0 = '0;
    logic [15:0]      exp_tx = 16'd0;
    logic [WIDTH-1:0] snd_q[$];
    logic [WIDTH-1:0] rcv_q[$];

    ncl_sync_tx #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC), .TIMEOUT(TMO)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .rail1    (rail1),
        .rail0    (rail0),
        .ki       (ki),
        .timeout  (timeout),
        .tx_count (tx_count)
    );

    always #5 clk = ~clk;

    // Rails must always be all-NULL or a complete DATA word, never 1/1, never DATA->DATA.
    always @(negedge clk) begin
        if ((rail1 & rail0) != '0) begin
            viol_cnt <= viol_cnt + 1;
        end else if (((rail1 | rail0) != '0) && ((rail1 | rail0) != {WIDTH{1'b1}})) begin
            viol_cnt <= viol_cnt + 1;
        end else if (((prev1 | prev0) == {WIDTH{1'b1}}) && ((rail1 | rail0) == {WIDTH{1'b1}})
                     && (rail1 != prev1)) begin
            viol_cnt <= viol_cnt + 1;
        end
        prev1 <= rail1;
        prev0 <= rail0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        comp_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Bounded wait for NULL (want_data=0) or complete DATA (want_data=1).
    task automatic wait_rails(input bit want_data, input int budget, output bit ok);
        int n;
        n  = 0;
        ok = want_data ? ((rail1 | rail0) == {WIDTH{1'b1}}) : ((rail1 | rail0) == '0);
        while (!ok && n < budget) begin
            @(negedge clk);
            n++;
            ok = want_data ? ((rail1 | rail0) == {WIDTH{1'b1}}) : ((rail1 | rail0) == '0);
        end
    endtask

    task automatic wait_ready(input int budget, output bit ok);
        int n;
        n  = 0;
        ok = in_ready;
        while (!ok && n < budget) begin
            @(negedge clk);
            n++;
            ok = in_ready;
        end
    endtask

    initial begin
        bit               ok;
        int               bad_data;
        int               bad_wait;
        logic [WIDTH-1:0] w;

        // 1: reset with ki high, then ready after SYNC+1 edges.
        tick(2);
        check("rst_rail1", 32'(rail1), 32'd0);
        check("rst_rail0", 32'(rail0), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_txcnt", 32'(tx_count), 32'd0);
        rst_n = 1'b1;
        tick(SYNC);
        check("ready_early", 32'(in_ready), 32'd0);
        tick(1);
        check("ready_rise", 32'(in_ready), 32'd1);
        check("ready_rails_null", 32'(rail1 | rail0), 32'd0);

        // 2: single word 0xA5 with ki echo after 3 cycles.
        in_valid = 1'b1;
        in_data  = 8'hA5;
        tick(1);
        check("a5_rail1", 32'(rail1), 32'hA5);
        check("a5_rail0", 32'(rail0), 32'h5A);
        check("a5_ready_low", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        in_data  = 8'h3C;
        tick(3);
        check("a5_hold", 32'(rail1), 32'hA5);
        ki = 1'b0;
        tick(SYNC);
        check("a5_hold_sync", 32'(rail1), 32'hA5);
        tick(1);
        exp_tx = exp_tx + 16'd1;
        check("a5_null", 32'(rail1 | rail0), 32'd0);
        check("a5_txcnt", 32'(tx_count), 32'(exp_tx));
        ki = 1'b1;
        tick(SYNC + 1);
        check("a5_ready_again", 32'(in_ready), 32'd1);
        check("a5_no_timeout", 32'(timeout), 32'd0);

        // Illegal ki drop while idle: nothing changes.
        ki = 1'b0;
        tick(SYNC + 3);
        check("idle_ki_drop_ready", 32'(in_ready), 32'd1);
        check("idle_ki_drop_null", 32'(rail1 | rail0), 32'd0);
        ki = 1'b1;
        tick(SYNC + 1);

        // 4: timeout while ki stays high after DATA.
        in_valid = 1'b1;
        w        = 8'($urandom());
        in_data  = w;
        tick(1);
        in_valid = 1'b0;
        check("tmo_data", 32'(rail1), 32'(w));
        tick(TMO);
        check("tmo_not_yet", 32'(timeout), 32'd0);
        tick(1);
        check("tmo_set", 32'(timeout), 32'd1);
        ki = 1'b0;
        tick(SYNC + 1);
        exp_tx = exp_tx + 16'd1;
        check("tmo_null", 32'(rail1 | rail0), 32'd0);
        check("tmo_txcnt", 32'(tx_count), 32'(exp_tx));
        ki = 1'b1;
        tick(SYNC + 1);
        check("tmo_sticky", 32'(timeout), 32'd1);
        check("tmo_ready", 32'(in_ready), 32'd1);

        // 5: reset in the middle of a DATA wavefront.
        in_valid = 1'b1;
        in_data  = 8'hFF;
        tick(1);
        in_valid = 1'b0;
        check("mid_data", 32'(rail1), 32'hFF);
        ki = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_rails", 32'({rail1, rail0}), 32'd0);
        check("mid_rst_txcnt", 32'(tx_count), 32'd0);
        check("mid_rst_timeout", 32'(timeout), 32'd0);
        exp_tx = 16'd0;
        @(negedge clk);
        rst_n = 1'b1;
        tick(5);
        check("post_rst_ready_low", 32'(in_ready), 32'd0);
        ki = 1'b1;
        tick(SYNC + 1);
        check("post_rst_ready", 32'(in_ready), 32'd1);

        // 3: 256 back-to-back random words, random receiver delays.
        bad_data = 0;
        bad_wait = 0;
        in_valid = 1'b1;
        in_data  = 8'($urandom());
        for (int k = 0; k < 256; k++) begin
            wait_ready(60, ok);
            if (!ok) bad_wait++;
            snd_q.push_back(in_data);
            tick(1);
            if ((rail1 | rail0) == {WIDTH{1'b1}}) begin
                rcv_q.push_back(rail1);
            end else begin
                bad_data++;
            end
            if (k == 255) in_valid = 1'b0;
            else          in_data  = 8'($urandom());
            tick(int'($urandom_range(0, 20)));
            ki = 1'b0;
            wait_rails(1'b0, 60, ok);
            if (!ok) bad_wait++;
            exp_tx = exp_tx + 16'd1;
            tick(int'($urandom_range(0, 20)));
            ki = 1'b1;
        end
        check("rnd_data_on_rails", 32'(bad_data), 32'd0);
        check("rnd_wait_bounds", 32'(bad_wait), 32'd0);
        check("rnd_rcv_len", 32'(rcv_q.size()), 32'(snd_q.size()));
        for (int k = 0; k < snd_q.size() && k < rcv_q.size(); k++) begin
            check("rnd_stream", 32'(rcv_q[k]), 32'(snd_q[k]));
        end
        tick(1);
        check("rnd_txcnt", 32'(tx_count), 32'(exp_tx));

        // 6: counter wrap from 0xFFFF.
        wait_ready(60, ok);
        check("wrap_ready_wait", 32'(ok), 32'd1);
        force dut.tx_count_r = 16'hFFFF;
        #1 release dut.tx_count_r;
        #1;
        exp_tx = 16'hFFFF;
        check("wrap_preset", 32'(tx_count), 32'(exp_tx));
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'h01;
        tick(1);
        in_valid = 1'b0;
        ki = 1'b0;
        tick(SYNC + 1);
        exp_tx = exp_tx + 16'd1;
        check("wrap_txcnt", 32'(tx_count), 32'(exp_tx));
        ki = 1'b1;
        wait_ready(60, ok);
        in_valid = 1'b1;
        in_data  = 8'h80;
        tick(1);
        in_valid = 1'b0;
        ki = 1'b0;
        tick(SYNC + 1);
        exp_tx = exp_tx + 16'd1;
        check("wrap_txcnt_next", 32'(tx_count), 32'(exp_tx));
        ki = 1'b1;
        tick(SYNC + 2);

        check("rail_invariants", 32'(viol_cnt), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", comp_cnt, fail_cnt);
        $finish;
    end

endmodule
